msj_quadrature_feedback: RTL and testbench
==========================================

# msj_quadrature_feedback

Sensor-side feedback front end for the MSJ platform PD controller. It decodes one quadrature encoder (4x), keeps a signed 32-bit position count, and estimates velocity as counts per update window. At the end of every window it issues the one-cycle `update_controller` strobe that the controller consumes. One instance per joint drives the controller's `position`, `velocity` and `update_controller` inputs.

## Interface
- `ERR_W`, default 16: width of the illegal-transition counter.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enc_a`  in  1  encoder channel A; asynchronous to `clock`.
- `enc_b`  in  1  encoder channel B; asynchronous to `clock`.
- `update_period`  in  32  unsigned window length in clock cycles; values 0 and 1 are treated as 2.
- `zero_position`  in  1  synchronous level; while high, the position is cleared.
- `position`  out  32  signed accumulated count.
- `velocity`  out  32  signed count delta over the last completed window.
- `update_controller`  out  1  one-cycle high pulse at the end of each window.
- `error_count`  out  ERR_W  saturating count of illegal transitions.

## Operation
- Synchronizer:
  - `enc_a` and `enc_b` each pass through two flip-flops (`s1`, `s2`).
  - A `last` register holds the previous `s2` value of `{a,b}`.
- Arming:
  - After reset release, a 2-bit arm counter runs for 3 cycles.
  - While unarmed, `last` follows `s2` and nothing is counted or flagged.
  - This avoids a spurious count when the pins sit at 11 during reset.
- Decode, armed, comparing `{a,b}` `s2` against `last`:
  - Forward sequence 00→10→11→01→00 gives +1.
  - The reverse sequence gives −1.
  - No change gives 0.
  - Both bits changing is illegal: count 0, and `error_count` increments, saturating at all-ones.
- Position:
  - `pos_next = position + delta` (0, +1 or −1), with 32-bit two's-complement wrap.
  - `zero_position` high forces `pos_next = 0`. This has priority over a same-cycle delta; the delta is discarded.
- Window:
  - The 32-bit counter `cnt` increments every cycle.
  - When `cnt >= eff_period − 1`:
    - `cnt` ← 0.
    - `velocity` ← `pos_next − snap` (32-bit wrap; the result is correct across position wrap).
    - `snap` ← `pos_next`.
    - `update_controller` ← 1 for that single cycle.
  - `eff_period = max(update_period, 2)`, so strobes are never back-to-back.
  - Lowering `update_period` below the current `cnt` ends the window on the next cycle. Raising it extends the current window.
- Zero while running:
  - `zero_position` high also sets `snap` ← 0, so the next velocity is not polluted by the jump.
  - If zero and window end coincide: `velocity` ← 0 and `snap` ← 0.
- FSM: two states.
  - UNARMED → ARMED when the arm counter reaches 3.
  - ARMED persists until reset.

## Timing
- Reset values:
  - `position`, `velocity`, `update_controller`, `error_count`: 0.
  - `cnt`, `snap`, `s1`, `s2`, `last`, arm counter: 0.
  - State: UNARMED.
- Reset asserted mid-window: all of the above clear immediately. The first strobe after release comes `eff_period` cycles after the first armed cycle.
- Pin-to-position latency:
  - A transition sampled into `s1` at edge k reaches `s2` at k+1.
  - `position` is updated at edge k+2.
- Strobe:
  - `update_controller` is registered and high for exactly one cycle every `eff_period` cycles.
  - `velocity` changes on the same edge the strobe rises, so the consumer's rising-edge detector sees stable data.
- Zero: `position` reads 0 on the edge after `zero_position` is first sampled high.
- Throughput: at most one count per clock. Encoder edges closer than 2 clocks may be reported as illegal.

## Test plan
- Reset release with `enc_a=enc_b=1` held → after 10 cycles `position=0` and `error_count=0`.
- Drive 40 forward steps (00→10→11→01→00…), one every 8 clocks, with `update_period=1000` → `position=40`. The strobe fires every 1000 cycles, and the first window's `velocity` equals the counts accumulated in that window (e.g. 40 if all 40 steps fall inside it).
- Drive 10 reverse steps from `position=40` → `position=30`. The next window's `velocity` reflects −10 when those steps fall in that window.
- Jump 00→11 → `error_count=1` and `position` unchanged. Repeat 2^ERR_W+5 times → `error_count` saturates at all-ones.
- Coincident events with `position=1234`:
  - Pulse `zero_position` on a non-strobe cycle → `position=0` next edge; the following strobe gives `velocity` equal to counts after the zero only.
  - Pulse it on the strobe cycle → `velocity=0`.
- Wrap and period checks:
  - Preload near 0x7FFFFFFF via forward steps (force-initialized) and cross the wrap → `velocity=+N`.
  - `update_period=0` → strobe every 2 cycles.
  - Change 1000→5 mid-window at `cnt=500` → strobe on the next cycle.

Source files
------------

// File: rtl/msj_quadrature_feedback.sv
// Quadrature feedback front end for one joint of the MSJ PD controller.
// Decodes a 4x quadrature encoder into a signed 32-bit position, measures
// velocity as the count delta over a programmable window, and emits a
// one-cycle update strobe at the end of every window.
//
// Ports:
//   clock             system clock, rising edge
//   reset             asynchronous active-high reset
//   enc_a, enc_b      raw encoder channels (asynchronous to clock)
//   update_period     window length in cycles (0 and 1 behave as 2)
//   zero_position     synchronous level, clears position while high
//   position          accumulated count (two's complement, wraps)
//   velocity          count delta over the last completed window
//   update_controller one-cycle pulse at the end of each window
//   error_count       saturating count of illegal (double-bit) transitions
module msj_quadrature_feedback #(
    parameter int unsigned ERR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic [31:0]      update_period,
    input  logic             zero_position,
    output logic [31:0]      position,
    output logic [31:0]      velocity,
    output logic             update_controller,
    output logic [ERR_W-1:0] error_count
);

    typedef enum logic {StUnarmed, StArmed} state_t;

    state_t      state;
    logic [1:0]  arm_cnt;
    logic [1:0]  s1, s2, last;   // {a,b}
    logic [31:0] cnt;
    logic [31:0] snap;           // position at the start of the current window

    logic        armed;
    logic [1:0]  step;
    logic        count_up, count_dn, illegal;
    logic [31:0] pos_next;
    logic [31:0] last_cnt;
    logic        window_end;

    // Position of {a,b} along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        logic [1:0] ph;
        unique case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            2'b01:   ph = 2'd3;
            default: ph = 2'd0;
        endcase
        return ph;
    endfunction

    assign armed = (state == StArmed);

    always_comb begin
        // Phase difference modulo 4: 1 forward, 3 reverse, 2 both bits flipped.
        step     = phase_of(s2) - phase_of(last);
        count_up = armed && (step == 2'd1);
        count_dn = armed && (step == 2'd3);
        illegal  = armed && (step == 2'd2);

        if (zero_position) begin
            pos_next = '0;
        end else if (count_up) begin
            pos_next = position + 32'd1;
        end else if (count_dn) begin
            pos_next = position - 32'd1;
        end else begin
            pos_next = position;
        end

        // Terminal count is eff_period - 1 with eff_period = max(update_period, 2).
        last_cnt   = (update_period < 32'd2) ? 32'd1 : update_period - 32'd1;
        window_end = armed && (cnt >= last_cnt);
    end

    // Arming FSM: hold off decoding for a few cycles so the synchronizer and
    // the last register settle on the real pin state after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= StUnarmed;
            arm_cnt <= 2'd0;
        end else begin
            case (state)
                StUnarmed: begin
                    if (arm_cnt == 2'd3) begin
                        state <= StArmed;
                    end else begin
                        arm_cnt <= arm_cnt + 2'd1;
                    end
                end
                StArmed: state <= StArmed;
                default: state <= StUnarmed;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1                <= 2'b00;
            s2                <= 2'b00;
            last              <= 2'b00;
            position          <= '0;
            velocity          <= '0;
            update_controller <= 1'b0;
            error_count       <= '0;
            cnt               <= '0;
            snap              <= '0;
        end else begin
            s1       <= {enc_a, enc_b};
            s2       <= s1;
            last     <= s2;
            position <= pos_next;

            if (illegal && (error_count != {ERR_W{1'b1}})) begin
                error_count <= error_count + ERR_W'(1);
            end

            update_controller <= window_end;

            if (window_end) begin
                cnt  <= '0;
                // A zero inside the closing cycle discards the window's history.
                velocity <= zero_position ? 32'd0 : pos_next - snap;
                snap     <= pos_next;
            end else begin
                if (armed) begin
                    cnt <= cnt + 32'd1;
                end
                if (zero_position) begin
                    snap <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_msj_quadrature_feedback.sv
module tb_msj_quadrature_feedback;

    localparam int unsigned ERR_W = 4;

    logic             clock;
    logic             reset;
    logic             enc_a;
    logic             enc_b;
    logic [31:0]      update_period;
    logic             zero_position;
    logic [31:0]      position;
    logic [31:0]      velocity;
    logic             update_controller;
    logic [ERR_W-1:0] error_count;

    msj_quadrature_feedback #(.ERR_W(ERR_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .enc_a             (enc_a),
        .enc_b             (enc_b),
        .update_period     (update_period),
        .zero_position     (zero_position),
        .position          (position),
        .velocity          (velocity),
        .update_controller (update_controller),
        .error_count       (error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since reset release, pin history,
    // position, running window sum and window age.
    bit               model_on;
    int               m_e;
    logic [1:0]       m_h[$];
    logic [31:0]      m_pos, m_vel, m_acc, m_wcnt;
    logic             m_upd;
    logic [ERR_W-1:0] m_err;

    typedef struct {
        logic [1:0]  ab;
        int          hold;
        logic [31:0] pos;
        logic [3:0]  err;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int seq_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] seq_at(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_e = 0;
        m_h = {2'b00, 2'b00, 2'b00};
        m_pos = '0; m_vel = '0; m_acc = '0; m_wcnt = '0;
        m_upd = 1'b0; m_err = '0;
    endtask

    // One rising edge of behaviour: pins seen two edges ago are compared with
    // those seen three edges ago; counting starts on the fifth edge after reset.
    task automatic model_step(input logic [1:0] pins, input logic zero, input logic [31:0] per);
        logic [1:0]  cur, prev;
        logic [31:0] eff;
        int          d, k;
        bit          ill;
        m_e++;
        prev = m_h[0];
        cur  = m_h[1];
        void'(m_h.pop_front());
        m_h.push_back(pins);
        d = 0; ill = 0;
        if (m_e >= 5) begin
            k = (seq_idx(cur) - seq_idx(prev) + 4) % 4;
            if (k == 1) d = 1;
            else if (k == 3) d = -1;
            else if (k == 2) ill = 1;
        end
        if (ill && m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
        m_pos = zero ? 32'd0 : m_pos + 32'(d);
        m_upd = 1'b0;
        if (m_e >= 5) begin
            eff = (per < 2) ? 32'd2 : per;
            if (m_wcnt >= eff - 1) begin
                m_upd  = 1'b1;
                m_vel  = zero ? 32'd0 : m_acc + 32'(d);
                m_acc  = '0;
                m_wcnt = '0;
            end else begin
                m_wcnt = m_wcnt + 1;
                m_acc  = zero ? 32'd0 : m_acc + 32'(d);
            end
        end
    endtask

    // Called in the low phase; returns in the next low phase.
    task automatic tick();
        @(posedge clock);
        if (!reset && model_on) model_step({enc_a, enc_b}, zero_position, update_period);
        #1;
        if (model_on) begin
            chk("model_position", position, m_pos);
            chk("model_velocity", velocity, m_vel);
            chk("model_strobe", 32'(update_controller), 32'(m_upd));
            chk("model_errors", 32'(error_count), 32'(m_err));
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_position", position, 32'd0);
        chk("reset_velocity", velocity, 32'd0);
        chk("reset_strobe", 32'(update_controller), 32'd0);
        chk("reset_errors", 32'(error_count), 32'd0);
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic step_enc(input bit fwd, input int hold);
        int i;
        i = seq_idx({enc_a, enc_b}) + (fwd ? 1 : 3);
        {enc_a, enc_b} = seq_at(i);
        repeat (hold) tick();
    endtask

    task automatic wait_strobe(input int max_cycles, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!update_controller && n < max_cycles);
        chk(name, 32'(update_controller), 32'd1);
    endtask

    task automatic wait_wcnt(input logic [31:0] target, input string name);
        for (int i = 0; i < 1100 && m_wcnt != target; i++) tick();
        chk(name, m_wcnt, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        bit prev_upd, b2b;
        int r;

        vecs[0] = '{2'b11, 10, 32'd0,          4'd0};
        vecs[1] = '{2'b01, 4,  32'd1,          4'd0};
        vecs[2] = '{2'b00, 4,  32'd2,          4'd0};
        vecs[3] = '{2'b10, 4,  32'd3,          4'd0};
        vecs[4] = '{2'b00, 4,  32'd2,          4'd0};
        vecs[5] = '{2'b11, 4,  32'd2,          4'd1};
        vecs[6] = '{2'b10, 4,  32'd1,          4'd1};
        vecs[7] = '{2'b01, 4,  32'd1,          4'd2};
        vecs[8] = '{2'b11, 4,  32'd0,          4'd2};
        vecs[9] = '{2'b10, 4,  32'hFFFF_FFFF,  4'd2};

        reset = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
        update_period = 32'd1000; zero_position = 1'b0;
        model_on = 1'b1;
        model_reset();
        @(negedge clock);

        // Directed decode table, pins held at 11 through reset.
        do_reset();
        foreach (vecs[i]) begin
            {enc_a, enc_b} = vecs[i].ab;
            repeat (vecs[i].hold) tick();
            chk($sformatf("vec%0d_position", i), position, vecs[i].pos);
            chk($sformatf("vec%0d_errors", i), 32'(error_count), 32'(vecs[i].err));
        end

        // 40 forward steps in one window, then 10 reverse in the next.
        {enc_a, enc_b} = 2'b00;
        do_reset();
        repeat (6) tick();
        repeat (40) step_enc(1'b1, 8);
        chk("fwd40_position", position, 32'd40);
        wait_strobe(1100, "fwd40_strobe_seen");
        chk("fwd40_velocity", velocity, 32'd40);
        repeat (10) step_enc(1'b0, 8);
        chk("rev10_position", position, 32'd30);
        wait_strobe(1100, "rev10_strobe_seen");
        chk("rev10_velocity", velocity, -32'sd10);

        // Illegal jumps and error saturation.
        {enc_a, enc_b} = ~{enc_a, enc_b};
        repeat (3) tick();
        chk("illegal_errors", 32'(error_count), 32'd1);
        chk("illegal_position", position, 32'd30);
        repeat ((1 << ERR_W) + 4) begin
            {enc_a, enc_b} = ~{enc_a, enc_b};
            repeat (3) tick();
        end
        chk("sat_errors", 32'(error_count), 32'(2 ** ERR_W - 1));
        chk("sat_position", position, 32'd30);

        // Zero on a non-strobe cycle and on the strobe cycle.
        {enc_a, enc_b} = 2'b00;
        do_reset();
        repeat (6) tick();
        repeat (1234) step_enc(1'b1, 2);
        repeat (3) tick();
        chk("pos1234", position, 32'd1234);
        wait_wcnt(32'd10, "reach_cnt10");
        zero_position = 1'b1;
        tick();
        zero_position = 1'b0;
        chk("zero_position_cleared", position, 32'd0);
        chk("zero_no_strobe", 32'(update_controller), 32'd0);
        repeat (5) step_enc(1'b1, 4);
        wait_strobe(1100, "zero_strobe_seen");
        chk("zero_velocity_after", velocity, 32'd5);
        repeat (3) step_enc(1'b1, 4);
        wait_wcnt(32'd999, "reach_cnt999");
        zero_position = 1'b1;
        tick();
        zero_position = 1'b0;
        chk("zero_on_strobe_strobe", 32'(update_controller), 32'd1);
        chk("zero_on_strobe_velocity", velocity, 32'd0);
        chk("zero_on_strobe_position", position, 32'd0);

        // Period 0 behaves as 2.
        update_period = 32'd0;
        strobes = 0; prev_upd = 1'b0; b2b = 1'b0;
        repeat (20) begin
            tick();
            if (update_controller) strobes++;
            if (update_controller && prev_upd) b2b = 1'b1;
            prev_upd = update_controller;
        end
        chk("period0_strobes", 32'(strobes), 32'd10);
        chk("period0_no_back_to_back", 32'(b2b), 32'd0);

        // Shrinking the period below cnt ends the window on the next edge.
        update_period = 32'd1000;
        wait_wcnt(32'd500, "reach_cnt500");
        update_period = 32'd5;
        tick();
        chk("shrink_strobe", 32'(update_controller), 32'd1);
        tick();
        chk("shrink_strobe_single", 32'(update_controller), 32'd0);

        // Randomized traffic against the model, with one mid-window reset.
        update_period = 32'd17;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 30) {enc_a, enc_b} = seq_at(seq_idx({enc_a, enc_b}) + 1);
            else if (r < 45) {enc_a, enc_b} = seq_at(seq_idx({enc_a, enc_b}) + 3);
            else if (r < 48) {enc_a, enc_b} = ~{enc_a, enc_b};
            zero_position = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 99) == 0) update_period = $urandom_range(0, 30);
            if (c == 1500) do_reset();
            else tick();
        end
        zero_position = 1'b0;

        // Velocity across the 32-bit position wrap.
        model_on = 1'b0;
        update_period = 32'd1000;
        {enc_a, enc_b} = 2'b00;
        do_reset();
        repeat (6) tick();
        force dut.position = 32'h7FFF_FFFC;
        force dut.snap = 32'h7FFF_FFFC;
        #1;
        release dut.position;
        release dut.snap;
        repeat (8) step_enc(1'b1, 3);
        chk("wrap_position", position, 32'h8000_0004);
        wait_strobe(1100, "wrap_strobe_seen");
        chk("wrap_velocity", velocity, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
